// File: rtl/ncl_serial_add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ncl_seq_pkg
// Brief   : Dual-rail codes, sequencer state type and bit encoder.
// Rev     : 1.0 - initial release
// ============================================================================
package ncl_seq_pkg;

    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_0    = 2'b01;
    localparam logic [1:0] DR_1    = 2'b10;
    localparam logic [1:0] DR_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_NULL = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    function automatic logic [1:0] enc(input logic bit_i);
        return bit_i ? DR_1 : DR_0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ncl_serial_add_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : ncl_serial_add_seq_if
// Brief   : Host handshake plus dual-rail adder-cell bus of the sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
interface ncl_serial_add_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic [1:0]       add_a;
    logic [1:0]       add_b;
    logic [1:0]       add_cin;
    logic [1:0]       add_sum;
    logic [1:0]       add_cout;

    modport slave (
        input  start, a, b, cin, add_sum, add_cout,
        output busy, done, error, result, cout, add_a, add_b, add_cin
    );

    modport master (
        output start, a, b, cin, add_sum, add_cout,
        input  busy, done, error, result, cout, add_a, add_b, add_cin
    );
endinterface
`default_nettype wire

// File: rtl/ncl_serial_add_seq_dr_complete.sv
`default_nettype none
// ============================================================================
// Module  : ncl_dr_complete
// Brief   : Synchronizes the sum/carry rails and flags DATA, NULL or illegal.
// Rev     : 1.0 - initial release
// ============================================================================
module ncl_dr_complete
    import ncl_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sum_i,
    input  logic [1:0] cout_i,
    output logic       sum_bit_o,
    output logic       cout_bit_o,
    output logic       all_data_o,
    output logic       all_null_o,
    output logic       illegal_o
);

    // Each entry holds {cout rails, sum rails}; the last entry feeds detection.
    logic [3:0] sync_q [SYNC_STAGES];
    logic [1:0] w_sum;
    logic [1:0] w_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 4'b0000;
            end
        end else begin
            sync_q[0] <= {cout_i, sum_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign w_sum  = sync_q[SYNC_STAGES-1][1:0];
    assign w_cout = sync_q[SYNC_STAGES-1][3:2];

    assign illegal_o  = (w_sum == DR_ILL) || (w_cout == DR_ILL);
    assign all_null_o = (w_sum == DR_NULL) && (w_cout == DR_NULL);
    assign all_data_o = !illegal_o && (w_sum != DR_NULL) && (w_cout != DR_NULL);
    assign sum_bit_o  = (w_sum == DR_1);
    assign cout_bit_o = (w_cout == DR_1);

endmodule
`default_nettype wire

// File: rtl/ncl_serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module  : ncl_serial_add_seq
// Brief   : Digit-serial, LSB-first adder driving one dual-rail NCL full adder.
// Rev     : 1.0 - initial release
// ============================================================================
module ncl_serial_add_seq
    import ncl_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    ncl_serial_add_seq_if.slave bus_io
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               error_q, error_d;
    logic [1:0]         add_a_q, add_a_d;
    logic [1:0]         add_b_q, add_b_d;
    logic [1:0]         add_cin_q, add_cin_d;

    logic               w_sum_bit;
    logic               w_cout_bit;
    logic               w_all_data;
    logic               w_all_null;
    logic               w_illegal;
    logic               w_timeout;

    ncl_dr_complete #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_complete (
        .clk        (clk),
        .rst_n      (rst_n),
        .sum_i      (bus_io.add_sum),
        .cout_i     (bus_io.add_cout),
        .sum_bit_o  (w_sum_bit),
        .cout_bit_o (w_cout_bit),
        .all_data_o (w_all_data),
        .all_null_o (w_all_null),
        .illegal_o  (w_illegal)
    );

    assign w_timeout = (timer_q == C_TMR_LAST);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        timer_d  = '0;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        error_d  = error_q;

        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (bus_io.start) begin
                    a_d      = bus_io.a;
                    b_d      = bus_io.b;
                    carry_d  = bus_io.cin;
                    result_d = '0;
                    cout_d   = 1'b0;
                    error_d  = 1'b0;
                    idx_d    = '0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                timer_d = timer_q + 1'b1;
                if (w_illegal) begin
                    error_d = 1'b1;
                    state_d = ST_ERR;
                end else if (w_all_data) begin
                    result_d[idx_q] = w_sum_bit;
                    carry_d         = w_cout_bit;
                    timer_d         = '0;
                    state_d         = ST_NULL;
                end else if (w_timeout) begin
                    error_d = 1'b1;
                    state_d = ST_ERR;
                end
            end
            ST_NULL: begin
                timer_d = timer_q + 1'b1;
                if (w_illegal) begin
                    error_d = 1'b1;
                    state_d = ST_ERR;
                end else if (w_all_null) begin
                    timer_d = '0;
                    if (idx_q == C_IDX_LAST) begin
                        cout_d  = carry_q;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_DATA;
                    end
                end else if (w_timeout) begin
                    error_d = 1'b1;
                    state_d = ST_ERR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Adder inputs are computed from the next state so they only move on state entry.
        add_a_d   = DR_NULL;
        add_b_d   = DR_NULL;
        add_cin_d = DR_NULL;
        if (state_d == ST_DATA) begin
            add_a_d   = enc(a_d[idx_d]);
            add_b_d   = enc(b_d[idx_d]);
            add_cin_d = enc(carry_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            timer_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            error_q   <= 1'b0;
            add_a_q   <= DR_NULL;
            add_b_q   <= DR_NULL;
            add_cin_q <= DR_NULL;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            error_q   <= error_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
        end
    end

    assign bus_io.busy    = (state_q == ST_DATA) || (state_q == ST_NULL) || (state_q == ST_DONE);
    assign bus_io.done    = (state_q == ST_DONE);
    assign bus_io.error   = error_q;
    assign bus_io.result  = result_q;
    assign bus_io.cout    = cout_q;
    assign bus_io.add_a   = add_a_q;
    assign bus_io.add_b   = add_b_q;
    assign bus_io.add_cin = add_cin_q;

endmodule
`default_nettype wire

// File: tb/tb_ncl_serial_add_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_ncl_serial_add_seq
// Brief   : Directed bench with a dual-rail full-adder model and a delay line.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_ncl_serial_add_seq;
    import ncl_seq_pkg::*;

    localparam int WIDTH = 8;
    localparam int SS    = 2;
    localparam int TO    = 15;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic       force_ill;
    logic       hold_null;
    int         dly;
    logic [1:0] m_sum;
    logic [1:0] m_cout;
    logic [3:0] dline [16];
    logic [3:0] w_dly;

    ncl_serial_add_seq_if #(.WIDTH(WIDTH)) bus ();

    ncl_serial_add_seq #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SS),
        .TIMEOUT     (TO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Zero-delay dual-rail full adder; a delay line stretches its response.
    always_comb begin
        m_sum  = DR_NULL;
        m_cout = DR_NULL;
        if (bus.add_a != DR_NULL && bus.add_b != DR_NULL && bus.add_cin != DR_NULL) begin
            m_sum  = enc(bus.add_a[1] ^ bus.add_b[1] ^ bus.add_cin[1]);
            m_cout = enc((bus.add_a[1] & bus.add_b[1]) | (bus.add_a[1] & bus.add_cin[1]) |
                         (bus.add_b[1] & bus.add_cin[1]));
        end
    end

    always @(posedge clk) begin
        dline[0] <= {m_cout, m_sum};
        for (int i = 1; i < 16; i++) dline[i] <= dline[i-1];
    end

    assign w_dly        = (dly == 0) ? {m_cout, m_sum} : dline[dly-1];
    assign bus.add_sum  = force_ill ? 2'b11 : w_dly[1:0];
    assign bus.add_cout = hold_null ? 2'b00 : w_dly[3:2];

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c, input int maxc,
                          output int lat, output bit busy_ok, output logic [15:0] cins);
        int   t0;
        int   dg;
        logic prev;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = c; bus.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1; busy_ok = 1'b1; cins = '0; dg = 0; prev = 1'b0;
        for (int k = 0; k < maxc && lat < 0; k++) begin
            if (bus.add_a != DR_NULL && !prev) begin
                if (dg < 8) cins[2*dg +: 2] = bus.add_cin;
                dg++;
            end
            prev = (bus.add_a != DR_NULL);
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.done === 1'b1) lat = cyc - t0;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        force_ill = 1'b0; hold_null = 1'b0; dly = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.busy, bus.done, bus.error, bus.cout} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {bus.busy, bus.done, bus.error, bus.cout});
        end
        total++;
        if (bus.result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h want=00", bus.result); end
        total++;
        if ({bus.add_a, bus.add_b, bus.add_cin} !== 6'b0) begin
            bad++; $display("FAIL reset_adder_in got=%b want=000000", {bus.add_a, bus.add_b, bus.add_cin});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int lat; bit bok; logic [15:0] cins;
        run_op(8'h5A, 8'h3C, 1'b0, 200, lat, bok, cins);
        total++; if (lat !== 49) begin bad++; $display("FAIL basic_latency got=%0d want=49", lat); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL basic_busy got=dropped want=high"); end
        total++; if (bus.result !== 8'h96) begin bad++; $display("FAIL basic_result got=%h want=96", bus.result); end
        total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b want=0", bus.cout); end
        total++; if (cins !== 16'hAA55) begin bad++; $display("FAIL basic_add_cin got=%h want=aa55", cins); end
        @(negedge clk);
        total++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            bad++; $display("FAIL basic_done_pulse got=%b want=00", {bus.done, bus.busy});
        end
        repeat (3) @(negedge clk);
        total++; if (bus.result !== 8'h96) begin bad++; $display("FAIL basic_hold got=%h want=96", bus.result); end
    endtask

    task automatic test_carry_chain;
        int lat; bit bok; logic [15:0] cins;
        run_op(8'hFF, 8'h01, 1'b1, 200, lat, bok, cins);
        total++; if (lat !== 49) begin bad++; $display("FAIL chain_latency got=%0d want=49", lat); end
        total++; if (bus.result !== 8'h01) begin bad++; $display("FAIL chain_result got=%h want=01", bus.result); end
        total++; if (bus.cout !== 1'b1) begin bad++; $display("FAIL chain_cout got=%b want=1", bus.cout); end
        total++; if (cins !== 16'hAAAA) begin bad++; $display("FAIL chain_add_cin got=%h want=aaaa", cins); end
    endtask

    task automatic test_slow_adder;
        int lat; bit bok; logic [15:0] cins;
        dly = 5;
        repeat (8) @(negedge clk);
        run_op(8'hA5, 8'h5A, 1'b1, 400, lat, bok, cins);
        total++; if (lat !== 129) begin bad++; $display("FAIL slow_latency got=%0d want=129", lat); end
        total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL slow_result got=%h want=00", bus.result); end
        total++; if (bus.cout !== 1'b1) begin bad++; $display("FAIL slow_cout got=%b want=1", bus.cout); end
        total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL slow_error got=%b want=0", bus.error); end
        dly = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_illegal;
        int dg; int k2; int lat; bit found; bit bok; logic prev; logic [15:0] cins;
        @(negedge clk);
        bus.a = 8'h5A; bus.b = 8'h3C; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dg = 0; prev = 1'b0; found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (bus.add_a != DR_NULL && !prev) begin
                dg++;
                if (dg == 4) found = 1'b1;
            end
            prev = (bus.add_a != DR_NULL);
            if (!found) @(negedge clk);
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL illegal_digit3 got=missing want=seen"); end
        force_ill = 1'b1;
        k2 = 0;
        while (k2 < 10 && bus.error !== 1'b1) begin
            @(negedge clk);
            k2++;
        end
        total++;
        if (bus.error !== 1'b1 || k2 > SS + 1) begin
            bad++; $display("FAIL illegal_err_time got=%0d want<=%0d", k2, SS + 1);
        end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL illegal_busy got=%b want=0", bus.busy); end
        total++;
        if ({bus.add_a, bus.add_b, bus.add_cin} !== 6'b0) begin
            bad++; $display("FAIL illegal_adder_in got=%b want=000000", {bus.add_a, bus.add_b, bus.add_cin});
        end
        force_ill = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (bus.error !== 1'b1) begin bad++; $display("FAIL illegal_sticky got=%b want=1", bus.error); end
        run_op(8'h12, 8'h34, 1'b0, 200, lat, bok, cins);
        total++; if (bus.error !== 1'b0) begin bad++; $display("FAIL illegal_clear got=%b want=0", bus.error); end
        total++; if (bus.result !== 8'h46) begin bad++; $display("FAIL illegal_recover got=%h want=46", bus.result); end
        total++; if (lat !== 49) begin bad++; $display("FAIL illegal_recover_lat got=%0d want=49", lat); end
    endtask

    task automatic test_timeout_busy_start;
        int t0; int err_lat; bit addok;
        hold_null = 1'b1;
        @(negedge clk);
        bus.a = 8'h5A; bus.b = 8'h3C; bus.cin = 1'b0; bus.start = 1'b1;
        t0 = cyc;
        err_lat = -1; addok = 1'b1;
        for (int k = 0; k < 40 && err_lat < 0; k++) begin
            @(negedge clk);
            bus.start = (k == 3 || k == 8);
            bus.a     = (k >= 3) ? 8'hA5 : 8'h5A;
            if (bus.error === 1'b1) err_lat = cyc - t0;
            else if (bus.add_a !== DR_0) addok = 1'b0;
        end
        bus.start = 1'b0;
        total++; if (err_lat !== 1 + TO) begin bad++; $display("FAIL timeout_cycles got=%0d want=%0d", err_lat, 1 + TO); end
        total++; if (addok !== 1'b1) begin bad++; $display("FAIL busy_start_ignored got=restarted want=held"); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL timeout_busy got=%b want=0", bus.busy); end
        hold_null = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_async_reset;
        int dg; bit found; logic prev;
        @(negedge clk);
        bus.a = 8'h5A; bus.b = 8'h3C; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dg = 0; prev = 1'b0; found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (bus.add_a != DR_NULL && !prev) begin
                dg++;
                if (dg == 5) found = 1'b1;
            end
            prev = (bus.add_a != DR_NULL);
            if (!found) @(negedge clk);
        end
        total++;
        if (found !== 1'b1 || bus.result !== 8'h06) begin
            bad++; $display("FAIL partial_result got=%h want=06", bus.result);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.error, bus.cout} !== 4'b0000) begin
            bad++; $display("FAIL async_rst_flags got=%b want=0000", {bus.busy, bus.done, bus.error, bus.cout});
        end
        total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL async_rst_result got=%h want=00", bus.result); end
        total++;
        if ({bus.add_a, bus.add_b, bus.add_cin} !== 6'b0) begin
            bad++; $display("FAIL async_rst_adder_in got=%b want=000000", {bus.add_a, bus.add_b, bus.add_cin});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_msb_carry;
        int lat; bit bok; logic [15:0] cins;
        run_op(8'h80, 8'h80, 1'b0, 200, lat, bok, cins);
        total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL msb_result got=%h want=00", bus.result); end
        total++; if (bus.cout !== 1'b1) begin bad++; $display("FAIL msb_cout got=%b want=1", bus.cout); end
        total++; if (lat !== 49) begin bad++; $display("FAIL msb_latency got=%0d want=49", lat); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_slow_adder();
        test_illegal();
        test_timeout_busy_start();
        test_async_reset();
        test_msb_carry();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
